// File: rtl/sie_rx_pkt_pkg.sv
// Shared constants and types for the receive-side packet decoder.
package sie_rx_pkt_pkg;

    // Decoder states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_DATA,
        ST_HSHK,
        ST_DROP
    } state_t;

    // Packet class derived from a PID nibble
    typedef enum logic [1:0] {
        PK_TOKEN,
        PK_HSHK,
        PK_DATA,
        PK_OTHER
    } pid_class_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [4:0]  CRC5_POLY      = 5'h14;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h06;
    localparam logic [15:0] CRC16_POLY     = 16'hA001;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    // PID byte is valid when the upper nibble is the complement of the lower
    function automatic logic pid_check(input logic [7:0] b);
        return b[3:0] == ~b[7:4];
    endfunction

    function automatic pid_class_t pid_class(input logic [3:0] pid);
        case (pid)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP:     return PK_TOKEN;
            PID_ACK, PID_NAK, PID_STALL, PID_NYET:   return PK_HSHK;
            PID_DATA0, PID_DATA1:                    return PK_DATA;
            default:                                 return PK_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/sie_rx_pkt_if.sv
// PHY-to-decoder byte stream plus decoder result signals.
interface sie_rx_pkt_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_err_i;
    logic       rx_ready_i;
    logic       usb_reset_i;
    logic [3:0] pid_o;
    logic [6:0] addr_o;
    logic [3:0] endp_o;
    logic       tok_valid_o;
    logic       hs_valid_o;
    logic       data_start_o;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       rx_end_o;
    logic       rx_ok_o;

    // PHY / SIE side: drives the byte stream, observes results
    modport master (
        output rx_data_i, rx_valid_i, rx_err_i, rx_ready_i, usb_reset_i,
        input  pid_o, addr_o, endp_o, tok_valid_o, hs_valid_o, data_start_o,
        input  data_o, data_valid_o, rx_end_o, rx_ok_o
    );

    // Decoder side
    modport slave (
        input  rx_data_i, rx_valid_i, rx_err_i, rx_ready_i, usb_reset_i,
        output pid_o, addr_o, endp_o, tok_valid_o, hs_valid_o, data_start_o,
        output data_o, data_valid_o, rx_end_o, rx_ok_o
    );
endinterface

// File: rtl/sie_rx_pkt_usb_crc.sv
// Reflected CRC register with a one-byte-per-cycle combinational update.
module usb_crc #(
    parameter int unsigned       WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] crc
);

    logic [WIDTH-1:0] crc_nxt;

    // Shift the eight data bits in LSB first
    always_comb begin
        crc_nxt = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_nxt[0] ^ data[i]) begin
                crc_nxt = (crc_nxt >> 1) ^ POLY;
            end else begin
                crc_nxt = crc_nxt >> 1;
            end
        end
    end

    // CRC register: preset on clear, update on each accepted byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= INIT;
        end else if (clear) begin
            crc <= INIT;
        end else if (en) begin
            crc <= crc_nxt;
        end
    end

endmodule

// File: rtl/sie_rx_pkt.sv
// Receive packet decoder: PID check, token/handshake/data classification,
// CRC5/CRC16 checking and CRC-stripped payload forwarding.
module sie_rx_pkt
    import sie_rx_pkt_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned CNT_W       = $clog2(MAX_PAYLOAD + 3)
) (
    input logic         clk_i,
    input logic         rst_i,
    sie_rx_pkt_if.slave rx
);

    localparam logic [CNT_W-1:0] CNT_TOK      = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [CNT_W-1:0] CNT_EMIT_MAX = CNT_W'(MAX_PAYLOAD + 1);

    state_t           state, state_nxt;
    logic             ev_err, ev_byte, ev_eop, abort;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       buf_new, buf_old;
    logic [4:0]       crc5;
    logic [15:0]      crc16;
    logic             crc_clear, emit;
    pid_class_t       in_class;

    logic [3:0] pid_q;
    logic [6:0] addr_q;
    logic [3:0] endp_q;
    logic [7:0] data_q;
    logic       tok_nxt, hs_nxt, start_nxt, end_nxt, ok_nxt;
    logic       tok_q, hs_q, start_q, end_q, ok_q, dv_q;

    assign ev_err   = rx.rx_ready_i & rx.rx_err_i;
    assign ev_byte  = rx.rx_ready_i & rx.rx_valid_i & ~rx.rx_err_i;
    assign ev_eop   = rx.rx_ready_i & ~rx.rx_valid_i & ~rx.rx_err_i;
    assign abort    = rx.usb_reset_i;
    assign in_class = pid_class(rx.rx_data_i[3:0]);

    assign crc_clear = abort || (state == ST_IDLE);
    // Byte N leaves the two-entry buffer when byte N+2 arrives, so the last
    // two bytes (the CRC) are never forwarded.
    assign emit = (state == ST_DATA) && ev_byte && !abort &&
                  (cnt >= CNT_TOK) && (cnt <= CNT_EMIT_MAX);

    usb_crc #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (crc_clear),
        .en    ((state == ST_TOKEN) && ev_byte),
        .data  (rx.rx_data_i),
        .crc   (crc5)
    );

    usb_crc #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (crc_clear),
        .en    ((state == ST_DATA) && ev_byte),
        .data  (rx.rx_data_i),
        .crc   (crc16)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode from the PHY events
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ev_byte) begin
                        if (!pid_check(rx.rx_data_i)) begin
                            state_nxt = ST_DROP;
                        end else begin
                            case (in_class)
                                PK_TOKEN: state_nxt = ST_TOKEN;
                                PK_HSHK:  state_nxt = ST_HSHK;
                                PK_DATA:  state_nxt = ST_DATA;
                                default:  state_nxt = ST_DROP;
                            endcase
                        end
                    end
                end
                ST_TOKEN: begin
                    if (ev_err || ev_eop)                 state_nxt = ST_IDLE;
                    else if (ev_byte && cnt == CNT_TOK)   state_nxt = ST_DROP;
                end
                ST_HSHK: begin
                    if (ev_err || ev_eop)                 state_nxt = ST_IDLE;
                    else if (ev_byte)                     state_nxt = ST_DROP;
                end
                ST_DATA: begin
                    if (ev_err || ev_eop)                 state_nxt = ST_IDLE;
                    else if (ev_byte && cnt == CNT_LAST)  state_nxt = ST_DROP;
                end
                ST_DROP: begin
                    if (ev_err || ev_eop)                 state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Result pulses for the following cycle
    always_comb begin
        tok_nxt   = 1'b0;
        hs_nxt    = 1'b0;
        start_nxt = 1'b0;
        end_nxt   = 1'b0;
        ok_nxt    = 1'b0;
        if (!abort) begin
            start_nxt = (state == ST_IDLE) && ev_byte &&
                        pid_check(rx.rx_data_i) && (in_class == PK_DATA);
            if ((state != ST_IDLE) && (ev_err || ev_eop)) begin
                end_nxt = 1'b1;
                if (ev_eop) begin
                    case (state)
                        ST_TOKEN: begin
                            if (cnt == CNT_TOK && crc5 == CRC5_RESIDUAL) begin
                                tok_nxt = 1'b1;
                                ok_nxt  = 1'b1;
                            end
                        end
                        ST_HSHK: begin
                            hs_nxt = 1'b1;
                            ok_nxt = 1'b1;
                        end
                        ST_DATA: begin
                            ok_nxt = (cnt >= CNT_TOK) && (crc16 == CRC16_RESIDUAL);
                        end
                        default: ok_nxt = 1'b0;
                    endcase
                end
            end
        end
    end

    // Output pulse registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tok_q   <= 1'b0;
            hs_q    <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            ok_q    <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            tok_q   <= tok_nxt;
            hs_q    <= hs_nxt;
            start_q <= start_nxt;
            end_q   <= end_nxt;
            ok_q    <= ok_nxt;
            dv_q    <= emit;
        end
    end

    // Byte counter, field latches and payload delay buffer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            buf_new <= '0;
            buf_old <= '0;
            pid_q   <= '0;
            addr_q  <= '0;
            endp_q  <= '0;
            data_q  <= '0;
        end else if (abort || state == ST_IDLE) begin
            cnt <= '0;
            if (!abort && ev_byte && pid_check(rx.rx_data_i)) begin
                pid_q <= rx.rx_data_i[3:0];
            end
        end else if (ev_byte) begin
            if (state == ST_TOKEN) begin
                if (cnt == CNT_W'(0)) begin
                    addr_q    <= rx.rx_data_i[6:0];
                    endp_q[0] <= rx.rx_data_i[7];
                end else if (cnt == CNT_W'(1)) begin
                    endp_q[3:1] <= rx.rx_data_i[2:0];
                end
                if (cnt != CNT_TOK) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (state == ST_DATA) begin
                buf_old <= buf_new;
                buf_new <= rx.rx_data_i;
                if (emit) begin
                    data_q <= buf_old;
                end
                if (cnt != CNT_LAST) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rx.pid_o        = pid_q;
    assign rx.addr_o       = addr_q;
    assign rx.endp_o       = endp_q;
    assign rx.data_o       = data_q;
    assign rx.tok_valid_o  = tok_q;
    assign rx.hs_valid_o   = hs_q;
    assign rx.data_start_o = start_q;
    assign rx.data_valid_o = dv_q;
    assign rx.rx_end_o     = end_q;
    assign rx.rx_ok_o      = ok_q;

endmodule

// File: doc/sie_rx_pkt.md
Name: sie_rx_pkt

Overview:
Receive-side packet decoder, directly downstream of the full-speed PHY receiver; consumes its byte stream and end/error strobes. Validates the PID and classifies the packet as token, handshake or data. Checks CRC5 on tokens and CRC16 on data. Forwards payload bytes with both CRC bytes stripped, and emits one-cycle result pulses to the SIE control logic.

Parameters:
MAX_PAYLOAD, 64, max data payload bytes (CRC excluded); longer packets are errors
CNT_W, ceil_log2(MAX_PAYLOAD+3), width of internal byte counter

Ports:
clk_i  in  1  same clock as PHY receiver (12MHz*BIT_SAMPLES)
rst_i  in  1  asynchronous, active-high reset
rx_data_i  in  8  byte from PHY, LSB = first bit on bus
rx_valid_i  in  1  PHY byte-valid level
rx_err_i  in  1  PHY error level
rx_ready_i  in  1  PHY one-cycle qualifier strobe
usb_reset_i  in  1  bus reset from PHY; synchronous abort
pid_o  out  4  PID of last accepted packet
addr_o  out  7  token address
endp_o  out  4  token endpoint (SOF frame number = {endp_o, addr_o})
tok_valid_o  out  1  pulse: token received, CRC5 good
hs_valid_o  out  1  pulse: handshake received
data_start_o  out  1  pulse: DATA0/DATA1 PID accepted
data_o  out  8  payload byte
data_valid_o  out  1  pulse: data_o valid
rx_end_o  out  1  pulse: packet finished, good or bad
rx_ok_o  out  1  qualifies rx_end_o; 1 = packet good

Behaviour:
- Event decode per cycle: ERR = rx_ready_i & rx_err_i (highest priority); BYTE = rx_ready_i & rx_valid_i & ~rx_err_i; EOP = rx_ready_i & ~rx_valid_i & ~rx_err_i.
- Reset (rst_i): all outputs 0; pid_o/addr_o/endp_o/data_o = 0; state ST_IDLE.
- usb_reset_i high: next cycle state ST_IDLE, counters cleared. No rx_end_o for an aborted packet. Held-high keeps block idle.
- States: ST_IDLE, ST_TOKEN, ST_DATA, ST_HSHK, ST_DROP.
- ST_IDLE on BYTE: check rx_data_i[3:0] == ~rx_data_i[7:4]. On fail -> ST_DROP. On pass, latch pid_o, then:
  - OUT 0001, IN 1001, SOF 0101, SETUP 1101 -> ST_TOKEN.
  - ACK 0010, NAK 1010, STALL 1110, NYET 0110 -> ST_HSHK.
  - DATA0 0011, DATA1 1011 -> ST_DATA; data_start_o pulses next cycle.
  - Any other PID -> ST_DROP.
- ST_IDLE on EOP or ERR: ignored; no pulse.
- ST_TOKEN:
  - Byte 1 -> addr_o = b[6:0], endp_o[0] = b[7]; byte 2 -> endp_o[3:1] = b[2:0].
  - CRC5 over both bytes. Register shifts right, poly 0x14, init 0x1F; good residual 0x06.
  - EOP after exactly 2 bytes with good CRC -> tok_valid_o + rx_end_o with rx_ok_o=1, next cycle.
  - Third byte -> ST_DROP.
- ST_HSHK: EOP -> hs_valid_o + rx_end_o/rx_ok_o=1 next cycle. Any BYTE -> ST_DROP.
- ST_DATA:
  - CRC16 over every byte after the PID. Register shifts right, poly 0xA001, init 0xFFFF; good residual 0xB001.
  - 8-bit CRC update is combinational in one cycle; BYTE strobes are >= 8*BIT_SAMPLES cycles apart.
  - Two-entry delay buffer strips the CRC: on the BYTE carrying byte N+2, byte N is emitted. data_o/data_valid_o appear the cycle after that BYTE.
  - Byte count above MAX_PAYLOAD+2 -> ST_DROP. Bytes already emitted stay emitted.
  - On EOP: rx_ok_o=1 iff count >= 2 and residual good. Bytes still in the buffer are discarded.
- Any state except ST_IDLE/ST_DROP on ERR, or on EOP that does not meet the state's condition:
  - Next cycle rx_end_o=1, rx_ok_o=0; -> ST_IDLE.
  - No tok_valid_o/hs_valid_o in that case.
- ST_DROP: ignore BYTE. On EOP or ERR -> rx_end_o=1, rx_ok_o=0 next cycle; -> ST_IDLE.
- All pulses last exactly one cycle. rx_ok_o is 0 whenever rx_end_o is 0.
- tok_valid_o, hs_valid_o and rx_end_o assert in the same cycle.
- addr_o/endp_o/pid_o hold until the next accepted packet overwrites them.

Decomposition:
- Shared package: PID constants (4-bit), state encodings, CRC5/CRC16 polynomials, init values and residual constants.
- One sub-module, usb_crc: parameterised width/poly/init, 8-bit-per-cycle combinational update plus register. Instantiated twice (width 5, width 16).

Test Plan:
- SETUP token bytes 2D 00 10 then EOP -> tok_valid_o=1, pid_o=D, addr_o=0, endp_o=0, rx_ok_o=1.
- DATA0 C3 80 06 00 01 00 00 40 00 DD 94, EOP:
  - data_start_o once.
  - data_valid_o exactly 8 times: 80 06 00 01 00 00 40 00.
  - rx_end_o with rx_ok_o=1.
- Same packet with last byte 95 -> same 8 bytes forwarded; rx_end_o with rx_ok_o=0.
- ACK D2 then EOP -> hs_valid_o, pid_o=2. Then bad PID C2 -> rx_end_o with rx_ok_o=0, no hs/tok pulse.
- DATA1 with MAX_PAYLOAD=8 and 11 payload bytes -> first 8 forwarded, then drop; EOP -> rx_ok_o=0.
- ERR strobe mid-DATA0 -> rx_end_o/rx_ok_o=0.
- usb_reset_i mid-token -> no pulses; next 2D 00 10 decodes normally.
